// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// Words are queued through a valid/ready write port and sent as
// start bit, LSB-first data, optional parity and one or two stop bits.
// A new frame starts directly after the last stop period if data is waiting.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tx_valid,
  input  logic [DATA_BITS-1:0]               tx_data,
  output logic                               tx_ready,
  output logic                               uart_txd,
  output logic                               uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [LW-1:0]        level_reg;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 wr_en;
  logic                 pop;
  logic [DATA_BITS-1:0] head_word;
  logic                 head_par;

  // Transmitter state
  state_t               state_reg, state_next;
  logic [BW-1:0]        baud_cnt_reg, baud_cnt_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 txd_reg, txd_next;
  logic                 baud_end;

  assign fifo_full  = (level_reg == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_reg == '0);
  assign wr_en      = tx_valid && !fifo_full;
  assign head_word  = fifo_mem[rd_ptr_reg];
  // Parity is captured together with the word so the shifter can consume the data freely.
  assign head_par   = (PARITY == 1) ? ~(^head_word) : (^head_word);
  assign baud_end   = (baud_cnt_reg == BW'(BAUD_CNT_MAX - 1));

  assign tx_ready     = !fifo_full;
  assign fifo_level   = level_reg;
  assign uart_txd     = txd_reg;
  assign uart_tx_busy = (state_reg != IDLE);

  // FIFO storage write port, kept free of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= tx_data;
    end
  end

  // Wrap-around pointers and fill level; a simultaneous push and pop leaves the level as is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Transmitter state register; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      txd_reg      <= txd_next;
    end
  end

  // Next-state logic; the line level for the coming bit is computed here so txd is registered.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_end ? '0 : baud_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    par_next      = par_reg;
    txd_next      = txd_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        txd_next      = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head_word;
          par_next   = head_par;
          txd_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
          txd_next     = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
            bit_cnt_next = '0;
            if (PARITY != 0) begin
              state_next = PAR;
              txd_next   = par_reg;
            end else begin
              state_next = STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = shift_reg >> 1;
            txd_next     = shift_reg[1];
          end
        end
      end
      PAR: begin
        if (baud_end) begin
          state_next   = STOP;
          bit_cnt_next = '0;
          txd_next     = 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
            bit_cnt_next = '0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = head_word;
              par_next   = head_par;
              txd_next   = 1'b0;
              state_next = START;
            end else begin
              txd_next   = 1'b1;
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats side by side (8N1, 8E1, 7O2).
// Accepted words go into a scoreboard with the edge they were written on;
// a per-instance monitor compares the serial line, busy, level and ready
// cycle by cycle against frames derived from the scoreboard.
module tb_uart_tx_fifo;
  localparam int BAUD = 10;

  typedef struct {
    logic [8:0] d;
    int         wedge;
  } ent_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_inst
      localparam int DB    = (gi == 2) ? 7 : 8;
      localparam int PM    = (gi == 0) ? 0 : ((gi == 1) ? 2 : 1);
      localparam int SB    = (gi == 2) ? 2 : 1;
      localparam int NBITS = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
      localparam int FL    = NBITS * BAUD;

      logic          rst_n = 1'b0;
      logic          tx_valid = 1'b0;
      logic [DB-1:0] tx_data = '0;
      logic          tx_ready;
      logic          uart_txd;
      logic          uart_tx_busy;
      logic [2:0]    fifo_level;
      bit            rst_q = 1'b0;
      bit            in_frame = 1'b0;
      ent_t          q [$];

      uart_tx_fifo #(
        .CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(DB),
        .PARITY(PM), .STOP_BITS(SB), .FIFO_DEPTH(4)
      ) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy),
        .fifo_level(fifo_level)
      );

      always @(posedge clk) rst_q <= rst_n;

      // Level of frame bit k for word d: start, data LSB first, parity, stop.
      function automatic bit exp_bit(input logic [8:0] d, input int k);
        logic [DB-1:0] w;
        w = d[DB-1:0];
        if (k == 0) return 1'b0;
        if (k <= DB) return w[k-1];
        if (PM != 0 && k == DB + 1) return (PM == 2) ? (^w) : ~(^w);
        return 1'b1;
      endfunction

      task automatic send(input logic [8:0] d);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = d[DB-1:0];
        while (!tx_ready && n < 2000) begin
          @(posedge clk); #1;
          n++;
        end
        if (tx_ready) q.push_back('{d: d, wedge: cyc + 1});
        else chk(tx_ready, $sformatf("g%0d ready_timeout", gi), 0, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
      endtask

      task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || in_frame) && n < 5000) begin
          @(posedge clk); #1;
          n++;
        end
        chk(q.size() == 0 && !in_frame, $sformatf("g%0d drain", gi), q.size(), 0);
      endtask

      // Monitor: one sample per cycle on the falling edge.
      initial begin : mon
        ent_t cur;
        int   pos;
        int   prev_end;
        int   bit_bad;
        int   exp_lvl;
        int   st;
        pos = 0; prev_end = 0; bit_bad = 0;
        cur = '{d: 9'h0, wedge: 0};
        forever begin
          @(negedge clk);
          if (cyc == 0) continue;
          if (!rst_q) begin
            chk(uart_txd === 1'b1 && uart_tx_busy === 1'b0 && fifo_level === 3'd0 && tx_ready === 1'b1,
                $sformatf("g%0d reset_state", gi),
                int'({uart_txd, uart_tx_busy, fifo_level, tx_ready}), 33);
            while (q.size() > 0 && q[0].wedge <= cyc) void'(q.pop_front());
            in_frame = 1'b0;
            prev_end = 0;
            continue;
          end
          if (!in_frame && uart_txd == 1'b0) begin
            chk(q.size() > 0, $sformatf("g%0d unexpected_frame", gi), cyc, 0);
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{d: 9'h0, wedge: cyc - 1};
            st = (cur.wedge + 1 > prev_end) ? cur.wedge + 1 : prev_end;
            chk(cyc == st, $sformatf("g%0d start_edge d=%0h", gi, cur.d[DB-1:0]), cyc, st);
            in_frame = 1'b1;
            pos = 0;
            bit_bad = 0;
          end
          if (in_frame) begin
            if (uart_txd !== exp_bit(cur.d, pos / BAUD) || uart_tx_busy !== 1'b1) bit_bad++;
            if (pos % BAUD == BAUD - 1) begin
              chk(bit_bad == 0, $sformatf("g%0d d=%0h bit%0d bad_samples", gi, cur.d[DB-1:0], pos / BAUD),
                  bit_bad, 0);
              bit_bad = 0;
            end
            pos++;
            if (pos == FL) begin
              in_frame = 1'b0;
              prev_end = cyc + 1;
            end
          end else begin
            chk(uart_tx_busy === 1'b0 && uart_txd === 1'b1, $sformatf("g%0d idle_line", gi),
                int'({uart_tx_busy, uart_txd}), 1);
          end
          exp_lvl = 0;
          foreach (q[i]) if (q[i].wedge <= cyc) exp_lvl++;
          chk(int'(fifo_level) == exp_lvl && tx_ready == (exp_lvl < 4),
              $sformatf("g%0d level_ready", gi), int'(fifo_level), exp_lvl);
        end
      end

      // Stimulus: directed words, a full-FIFO burst, random traffic, then a mid-frame reset.
      initial begin : stim
        int gap;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send((gi == 0) ? 9'h0A5 : ((gi == 1) ? 9'h007 : 9'h055));
        wait_drain();
        send(9'h007);
        wait_drain();
        send(9'h011); send(9'h022); send(9'h033); send(9'h044); send(9'h055);
        send(9'h0FF);
        wait_drain();
        for (int i = 0; i < 25; i++) begin
          gap = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 200) : $urandom_range(0, 3);
          repeat (gap) begin
            @(posedge clk); #1;
          end
          send(9'($urandom));
        end
        wait_drain();
        repeat (5) begin
          @(posedge clk); #1;
        end
        send(9'h03C); send(9'h0C3); send(9'h05A);
        repeat (42) begin
          @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (300) begin
          @(posedge clk); #1;
        end
        send(9'h01E);
        wait_drain();
        done[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin : finisher
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1] && done[2]))
      chk(done[0] && done[1] && done[2], "global_timeout", n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
